// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of {PC, instr} beats between fetch and decode, with full-stall and flush
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [31:0]                fetch_PC,
  input  logic [31:0]                fetch_instr,
  input  logic                       fetch_valid,
  input  logic                       flush,
  output logic                       stall_PC,
  output logic                       decode_valid,
  output logic [31:0]                decode_PC,
  output logic [31:0]                decode_instr,
  input  logic                       decode_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          full, enq, deq;
  always_comb begin
    full         = count == CW'(DEPTH);
    stall_PC     = full;
    decode_valid = count != '0;
    enq          = fetch_valid & ~full & ~flush;
    deq          = decode_valid & decode_ready & ~flush;
    decode_PC    = mem[rd_ptr][63:32];
    decode_instr = mem[rd_ptr][31:0];
  end
  // A full queue refuses the beat even when decode drains one this cycle; fetch re-presents it.
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) begin
        mem[wr_ptr] <= {fetch_PC, fetch_instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (deq) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(enq) - CW'(deq);
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: scoreboard bench; model queue fed at each edge, monitor compares head at negedge
module tb_fetch_queue;
  logic        clock = 0, reset = 1;
  logic [31:0] fetch_PC = 0, fetch_instr = 0;
  logic        fetch_valid = 0, flush = 0, decode_ready = 0;
  logic        stall_PC, decode_valid;
  logic [31:0] decode_PC, decode_instr;
  logic [2:0]  count;
  int          ncmp = 0, nerr = 0;
  logic [63:0] q[$];
  bit          last_acc;

  fetch_queue #(.DEPTH(4)) dut (
    .clock(clock), .reset(reset), .fetch_PC(fetch_PC), .fetch_instr(fetch_instr),
    .fetch_valid(fetch_valid), .flush(flush), .stall_PC(stall_PC),
    .decode_valid(decode_valid), .decode_PC(decode_PC), .decode_instr(decode_instr),
    .decode_ready(decode_ready), .count(count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: decides acceptance from the bench's own occupancy view.
  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      last_acc = 0;
    end else if (flush) begin
      q.delete();
      last_acc = 0;
    end else begin
      bit e, d;
      e = fetch_valid && q.size() < 4;
      d = q.size() != 0 && decode_ready;
      if (d) void'(q.pop_front());
      if (e) q.push_back({fetch_PC, fetch_instr});
      last_acc = e;
    end
  end

  always @(negedge clock) if (!reset) begin
    chk("count", 32'(count), 32'(q.size()));
    chk("stall_PC", 32'(stall_PC), 32'(q.size() == 4));
    chk("decode_valid", 32'(decode_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("decode_PC", decode_PC, q[0][63:32]);
      chk("decode_instr", decode_instr, q[0][31:0]);
    end
  end

  task automatic cyc(input bit fv, input logic [31:0] pc, input bit dr, input bit fl);
    fetch_valid = fv; fetch_PC = pc; fetch_instr = ~pc ^ 32'h5A00_00A5;
    decode_ready = dr; flush = fl;
    @(posedge clock); #1;
  endtask

  task automatic send(input logic [31:0] pc);
    int n = 0;
    do begin
      cyc(1, pc, bit'($urandom_range(0, 1)), 0);
      n++;
    end while (!last_acc && n < 50);
    if (!last_acc) begin
      nerr++;
      $display("FAIL send_timeout: pc %h not accepted after %0d cycles", pc, n);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 0;
    // Reset mid-stream with 3 entries held
    for (int i = 0; i < 3; i++) cyc(1, 32'h0200_0000 + 32'(4 * i), 0, 0);
    fetch_valid = 0;
    #1 reset = 1;
    #1;
    chk("rst_decode_valid", 32'(decode_valid), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_stall", 32'(stall_PC), 0);
    chk("rst_decode_PC", decode_PC, 0);
    q.delete();
    reset = 0;
    @(posedge clock); #1;
    // Fill, then a beat that must be refused
    for (int i = 0; i < 4; i++) cyc(1, 32'h0100_0000 + 32'(4 * i), 0, 0);
    cyc(1, 32'h0100_0010, 0, 0);
    cyc(1, 32'h0100_0010, 0, 0);
    chk("fill_head", decode_PC, 32'h0100_0000);
    cyc(0, 0, 0, 1);
    // Enqueue and dequeue together at count 2
    cyc(1, 32'h0100_0000, 0, 0);
    cyc(1, 32'h0100_0004, 0, 0);
    cyc(1, 32'h0100_0008, 1, 0);
    cyc(1, 32'h0100_000C, 1, 0);
    chk("ed_count", 32'(count), 2);
    // Full with dequeue: held beat enters one edge later
    cyc(1, 32'h0100_0010, 0, 0);
    cyc(1, 32'h0100_0014, 0, 0);
    cyc(1, 32'h0100_0018, 1, 0);
    chk("fd_count", 32'(count), 3);
    cyc(1, 32'h0100_0018, 0, 0);
    chk("fd_refill", 32'(count), 4);
    // Flush while full
    cyc(1, 32'h0100_001C, 1, 1);
    chk("fl_count", 32'(count), 0);
    cyc(1, 32'h0100_0100, 0, 0);
    chk("fl_new_head", decode_PC, 32'h0100_0100);
    cyc(0, 0, 1, 0);
    // Wrap with pseudo-random decode_ready
    for (int i = 0; i < 20; i++) send(32'h0300_0000 + 32'(4 * i));
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 0);
    chk("drain_count", 32'(count), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
